// File: rtl/ifm_pack_pkg.sv
// Shared types and constants for the IFM BRAM pack reader.
package ifm_pack_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  localparam int LANES          = 4;
  localparam int BYTES_PER_WORD = 4;
  localparam int RD_LATENCY     = 1;
  localparam int OUT_W          = 128;

  typedef logic [OUT_W-1:0] beat_t;
endpackage

// File: rtl/beat_fifo.sv
// First-word fall-through sync FIFO for packed beats; count feeds the read-issue credit check.
module beat_fifo
  import ifm_pack_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_pop;

  assign do_pop     = pop && (count != '0);
  assign head_valid = (count != '0);
  assign head_data  = mem[rd_ptr];

  // Push on a full FIFO with a concurrent pop reuses the slot being vacated.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ifm_bram_pack_reader.sv
// Reads a contiguous IFM region one 32-bit word per cycle and repacks it into 128-bit stream beats.
module ifm_bram_pack_reader
  import ifm_pack_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 20,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_beats,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);
  localparam int LW  = $clog2(LANES);
  localparam int CTW = $clog2(FIFO_DEPTH + 1);

  state_t                state_q, state_d;
  logic                  issue, last_lane, credit_ok;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [LW-1:0]         iss_lane, cap_lane;
  logic [CNT_WIDTH-1:0]  iss_beat, beats_total;
  logic                  vld_p0, bip;
  logic [DATA_WIDTH-1:0] lane_p1 [LANES-1];
  logic                  push, pop;
  logic [OUT_WIDTH-1:0]  push_data;
  logic [CTW-1:0]        fifo_count;
  logic                  base_lsb_unused;

  assign base_lsb_unused = |base_addr[1:0];
  assign last_lane       = (iss_lane == LW'(LANES - 1));
  assign push            = vld_p0 && (cap_lane == LW'(LANES - 1));
  assign pop             = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A new beat may start only if the FIFO can still hold it alongside the one being packed.
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    credit_ok = (int'(fifo_count) + int'(bip)) < FIFO_DEPTH;
    case (state_q)
      IDLE: if (start) state_d = (num_beats == '0) ? FINISH : ISSUE;
      ISSUE: begin
        busy  = 1'b1;
        issue = (iss_lane != '0) || credit_ok;
        if (issue && last_lane && (iss_beat == beats_total - CNT_WIDTH'(1))) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!bip && !vld_p0 && (fifo_count == '0)) state_d = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue stage: address generation and per-transfer counters
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr     <= '0;
      addr_nxt    <= '0;
      iss_lane    <= '0;
      iss_beat    <= '0;
      beats_total <= '0;
      vld_p0      <= 1'b0;
      cap_lane    <= '0;
      bip         <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        addr_nxt    <= {base_addr[ADDR_WIDTH-1:2], 2'b00};
        beats_total <= num_beats;
        iss_lane    <= '0;
        iss_beat    <= '0;
      end
      vld_p0 <= issue;
      if (issue) begin
        rd_addr  <= addr_nxt;
        addr_nxt <= addr_nxt + ADDR_WIDTH'(BYTES_PER_WORD);
        iss_lane <= last_lane ? '0 : iss_lane + LW'(1);
        if (last_lane) iss_beat <= iss_beat + CNT_WIDTH'(1);
      end
      if (vld_p0) cap_lane <= (cap_lane == LW'(LANES - 1)) ? '0 : cap_lane + LW'(1);
      if (issue && iss_lane == '0) bip <= 1'b1;
      else if (push)               bip <= 1'b0;
    end
  end

  // Capture stage: returning words land in the packer; the final lane bypasses into the FIFO
  always_ff @(posedge clk) begin
    if (vld_p0 && cap_lane != LW'(LANES - 1)) lane_p1[cap_lane] <= rd_data;
  end

  always_comb begin
    push_data = '0;
    for (int k = 0; k < LANES - 1; k++) push_data[k*DATA_WIDTH +: DATA_WIDTH] = lane_p1[k];
    push_data[(LANES-1)*DATA_WIDTH +: DATA_WIDTH] = rd_data;
  end

  beat_fifo #(
    .WIDTH(OUT_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (out_data),
    .head_valid(out_valid),
    .count     (fifo_count)
  );
endmodule

// File: tb/tb_ifm_bram_pack_reader.sv
// Directed bench for ifm_bram_pack_reader with a BRAM model whose word i holds the value i.
module tb_ifm_bram_pack_reader;
  localparam int DW = 32, OW = 128, AW = 32, CW = 20, FD = 2;
  localparam int BUDGET = 200;

  logic          clk = 1'b0;
  logic          rst, start, out_ready;
  logic [AW-1:0] base_addr, rd_addr;
  logic [CW-1:0] num_beats;
  logic [DW-1:0] rd_data;
  logic [OW-1:0] out_data;
  logic          out_valid, busy, done;

  always #5 clk = ~clk;

  // rd_addr is the BRAM's address register, so data for it is available the cycle after issue.
  assign rd_data = {2'b00, rd_addr[AW-1:2]};

  ifm_bram_pack_reader #(
    .DATA_WIDTH(DW), .OUT_WIDTH(OW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_beats(num_beats),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0]  base;
    logic [CW-1:0]  nb;
    int             mode;       // 0: ready high, 1: ready toggles, 2: ready low for 20 cycles
    logic [OW-1:0]  exp_first;
    logic [OW-1:0]  exp_last;
    int             exp_fv;     // cycle of first out_valid, -1 if never
    logic [AW-1:0]  exp_addr_end;
  } vec_t;

  logic [OW-1:0] beats[$];
  logic [AW-1:0] addr_hist [BUDGET];
  int            first_fv, done_cnt, done_c, last_acc, stall_bad;

  function automatic logic [OW-1:0] model_beat(input logic [AW-1:0] base, input int b);
    logic [OW-1:0] r;
    logic [29:0]   w;
    w = base[AW-1:2] + 30'(4 * b);
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = {2'b00, w + 30'(k)};
    return r;
  endfunction

  task automatic run(input logic [AW-1:0] base, input logic [CW-1:0] nb, input int mode);
    logic          prev_stall;
    logic [OW-1:0] prev_data;
    beats.delete();
    first_fv = -1; done_cnt = 0; done_c = -1; last_acc = -1; stall_bad = 0;
    prev_stall = 1'b0; prev_data = '0;
    base_addr = base; num_beats = nb; start = 1'b1; out_ready = (mode != 2);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      addr_hist[c] = rd_addr;
      if (done) begin done_cnt++; done_c = c; end
      if (out_valid && first_fv < 0) first_fv = c;
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_bad++;
      case (mode)
        1:       out_ready = (c % 2) == 1;
        2:       out_ready = (c >= 20);
        default: out_ready = 1'b1;
      endcase
      if (out_valid && out_ready) begin beats.push_back(out_data); last_acc = c; end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done_c >= 0 && c >= done_c + 2) break;
      @(negedge clk);
    end
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{32'h0000_0000, 20'd3, 0, 128'h00000003_00000002_00000001_00000000,
                128'h0000000B_0000000A_00000009_00000008, 5, 32'h0000_002C};
    vecs[1] = '{32'h0000_0040, 20'd1, 2, 128'h00000013_00000012_00000011_00000010,
                128'h00000013_00000012_00000011_00000010, 5, 32'h0000_004C};
    vecs[2] = '{32'h0000_0080, 20'd4, 1, 128'h00000023_00000022_00000021_00000020,
                128'h0000002F_0000002E_0000002D_0000002C, 5, 32'h0000_00BC};
    vecs[3] = '{32'h0000_0300, 20'd0, 0, 128'h0, 128'h0, -1, 32'h0000_00BC};
    vecs[4] = '{32'hFFFF_FFF8, 20'd1, 0, 128'h00000001_00000000_3FFFFFFF_3FFFFFFE,
                128'h00000001_00000000_3FFFFFFF_3FFFFFFE, 5, 32'h0000_0004};
    vecs[5] = '{32'h0000_0103, 20'd2, 0, 128'h00000043_00000042_00000041_00000040,
                128'h00000047_00000046_00000045_00000044, 5, 32'h0000_011C};

    rst = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; num_beats = '0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_out_data", out_data, 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_done", 128'(done), 128'd0);
    check("reset_rd_addr", 128'(rd_addr), 128'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run(vecs[i].base, vecs[i].nb, vecs[i].mode);
      check($sformatf("v%0d_nbeats", i), 128'(beats.size()), 128'(vecs[i].nb));
      if (beats.size() > 0) begin
        check($sformatf("v%0d_first", i), beats[0], vecs[i].exp_first);
        check($sformatf("v%0d_last", i), beats[beats.size()-1], vecs[i].exp_last);
      end
      for (int b = 0; b < beats.size(); b++)
        check($sformatf("v%0d_beat%0d", i, b), beats[b], model_beat(vecs[i].base, b));
      check($sformatf("v%0d_first_valid_cycle", i), 128'(first_fv), 128'(vecs[i].exp_fv));
      check($sformatf("v%0d_done_count", i), 128'(done_cnt), 128'd1);
      check($sformatf("v%0d_done_after_accept", i), 128'(done_c > last_acc), 128'd1);
      check($sformatf("v%0d_busy_end", i), 128'(busy), 128'd0);
      check($sformatf("v%0d_stall_stable", i), 128'(stall_bad), 128'd0);
      check($sformatf("v%0d_rd_addr_end", i), 128'(rd_addr), 128'(vecs[i].exp_addr_end));
      if (i == 0)
        for (int c = 1; c <= 12; c++)
          check($sformatf("v0_rd_addr_c%0d", c), 128'(addr_hist[c]), 128'(4 * (c - 1)));
      if (i == 1) check("v1_no_extra_reads", 128'(addr_hist[19]), 128'h4C);
      if (i == 3) check("v3_done_cycle", 128'(done_c), 128'd0);
      if (i == 4) begin
        check("v4_addr_c1", 128'(addr_hist[1]), 128'hFFFF_FFF8);
        check("v4_addr_c2", 128'(addr_hist[2]), 128'hFFFF_FFFC);
        check("v4_addr_c3", 128'(addr_hist[3]), 128'h0000_0000);
        check("v4_addr_c4", 128'(addr_hist[4]), 128'h0000_0004);
      end
    end

    // Reset in the middle of a three-beat transfer, just after the first beat is taken.
    base_addr = 32'h0; num_beats = 20'd3; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_beat0_valid", 128'(out_valid), 128'd1);
    check("mid_beat0_data", out_data, 128'h00000003_00000002_00000001_00000000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check("mid_rst_out_data", out_data, 128'd0);
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_rd_addr", 128'(rd_addr), 128'd0);
    done_cnt = 0;
    first_fv = -1;
    for (int c = 0; c < 20; c++) begin
      if (done) done_cnt++;
      if (out_valid) first_fv = c;
      @(negedge clk);
    end
    check("mid_rst_no_done", 128'(done_cnt), 128'd0);
    check("mid_rst_no_valid", 128'(first_fv), 128'(-1));
    run(32'h0000_0200, 20'd1, 0);
    check("post_rst_nbeats", 128'(beats.size()), 128'd1);
    if (beats.size() > 0)
      check("post_rst_beat", beats[0], 128'h00000083_00000082_00000081_00000080);
    check("post_rst_done", 128'(done_cnt), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ifm_bram_pack_reader.md
Name: ifm_bram_pack_reader

Overview:
- Read-side companion to the IFM BRAM, which takes 128-bit writes and returns 32-bit reads.
- Walks a contiguous byte-addressed region and issues one 32-bit read per cycle.
- Absorbs the BRAM's 1-cycle read latency and packs 4 consecutive words back into 128-bit beats.
- Hands beats to downstream consumers (PE feeder, DMA-out) over a valid/ready stream with backpressure.

Parameters:
- DATA_WIDTH, 32, BRAM word width.
- OUT_WIDTH, 128, output beat width; LANES = OUT_WIDTH/DATA_WIDTH = 4.
- ADDR_WIDTH, 32, byte-address width of rd_addr.
- CNT_WIDTH, 20, width of beat count.
- FIFO_DEPTH, 2, output beat buffer entries.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  byte address of first word; must be 4-aligned, bits [1:0] ignored
- num_beats  in  CNT_WIDTH  number of 128-bit beats to produce
- rd_addr  out  ADDR_WIDTH  byte address to BRAM (BRAM indexes word rd_addr>>2)
- rd_data  in  DATA_WIDTH  BRAM data_out, valid 1 cycle after the rd_addr it answers
- out_data  out  OUT_WIDTH  packed beat; lane k in bits [32k+31:32k], lane 0 = lowest address
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts when out_valid && out_ready
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after final beat is accepted

Behaviour:
- Reset: state=IDLE, rd_addr=0, out_data=0, out_valid=0, busy=0, done=0. FIFO, lane counter, beat counters and in-flight flag are cleared. Reset mid-transfer abandons the transfer: partial beat and buffered beats are discarded, no done pulse.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE:
  - start=1 latches base_addr (low 2 bits forced 0) and num_beats, sets busy=1, goes to ISSUE.
  - If num_beats==0, goes to FINISH instead.
- ISSUE:
  - Each cycle a read may be issued: rd_addr <= next address, in-flight bit set for the next cycle.
  - Address increments by 4 per issued read, modulo 2^ADDR_WIDTH (wrap is legal, no error).
  - Credit rule: lane 0 of a beat may be issued only if FIFO_DEPTH − fifo_count − beat_in_progress ≥ 1. Lanes 1..3 of a beat already begun are always issued back-to-back.
  - With out_ready held high, steady state is one read per cycle, no bubbles.
  - After the last lane of beat num_beats−1 is issued, go to DRAIN.
- Capture:
  - In the cycle after an issue, rd_data is written into packer lane lane_cnt and lane_cnt increments.
  - When lane 3 is written, the completed beat is pushed into the FIFO in that same cycle (write-through from the lane 3 data, no extra cycle) and lane_cnt returns to 0.
- Output:
  - out_data/out_valid come from the FIFO head; first-word fall-through, registered.
  - First beat's out_valid rises 5 cycles after start is sampled: 4 issue cycles + 1 latency cycle, then visible at the next edge.
  - Simultaneous push and pop on a full FIFO is legal; the credit rule guarantees no overflow.
  - out_data holds stable while out_valid && !out_ready.
- DRAIN: wait until packer is empty and FIFO is empty (last beat accepted), then go to FINISH.
- FINISH: done=1 for exactly one cycle, busy=0 in the same cycle, return to IDLE. A start in FINISH is ignored.
- start while busy: ignored, no effect on the running transfer.
- rd_addr holds its last value when no read is issued. The BRAM has no read enable; stale reads are harmless and not captured.

Decomposition:
- Package ifm_pack_pkg:
  - state enum typedef (IDLE/ISSUE/DRAIN/FINISH).
  - localparams LANES, BYTES_PER_WORD=4, RD_LATENCY=1.
  - beat typedef logic [OUT_WIDTH-1:0].
- One sub-module: beat_fifo, a parameterised FWFT sync FIFO (width OUT_WIDTH, depth FIFO_DEPTH) with count output used for credit.
- FSM, address generator and packer stay in the top.

Test Plan:
- BRAM model preloaded word[i]=i. start, base_addr=0, num_beats=3, out_ready=1 → beats 0x00000003_00000002_00000001_00000000, then …07_06_05_04, then …0B_0A_09_08. rd_addr sequence 0,4,…,44 on consecutive cycles. done pulses once; busy low afterward.
- base_addr=0x40 (word 16), num_beats=1, out_ready=0 for 20 cycles, then 1 → out_valid high and out_data=0x00000013_00000012_00000011_00000010 stable throughout stall. No more than 8 reads issued; FIFO never overflows.
- num_beats=4 with out_ready toggling 1/0 each cycle → 4 beats in order, no duplicates or drops, done after 4th acceptance.
- num_beats=0 → done pulse 1 cycle after start, no out_valid, rd_addr unchanged.
- base_addr=0xFFFFFFF8, num_beats=1 → rd_addr 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004 (wrap).
- rst asserted mid-transfer (after beat 1 of 3 accepted) → all outputs reset next cycle, no done. A new start then runs cleanly from its own base_addr.
